// File: rtl/updn_counter_pkg.sv
// Package exposing the shared counter encodings to every file of the block.
// No logic; constants only.
package updn_counter_pkg;
  `include "counter_defs.vh"
endpackage

// File: rtl/updn_counter_if.sv
// Control and status bundle for updn_counter; master drives controls, slave is the counter.
// Purely structural, no latency and no backpressure.
interface updn_counter_if #(
  parameter int DATAWIDTH = 8
);
  logic                 en;
  logic                 load;
  logic [DATAWIDTH-1:0] ld_val;
  logic                 dir;
  logic [DATAWIDTH-1:0] step;
  logic [DATAWIDTH-1:0] q;
  logic                 zero;
  logic                 tc;
  logic                 ovf;
  logic                 ovf_sticky;

  modport master (
    output en, load, ld_val, dir, step,
    input  q, zero, tc, ovf, ovf_sticky
  );

  modport slave (
    input  en, load, ld_val, dir, step,
    output q, zero, tc, ovf, ovf_sticky
  );
endinterface

// File: rtl/counter_defs.vh
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH
// Shared direction and overflow-mode encodings for the counter family.
localparam logic DIR_UP    = 1'b1;
localparam logic DIR_DOWN  = 1'b0;
localparam int   MODE_WRAP = 0;
localparam int   MODE_SAT  = 1;
`endif

// File: rtl/step_addsub.sv
// Combinational add/subtract one bit wider than the operands; r[DATAWIDTH] is carry or borrow.
// Zero latency, no backpressure.
module step_addsub
  import updn_counter_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 dir,
  output logic [DATAWIDTH:0]   r
);
  always_comb begin
    if (dir == DIR_UP) r = {1'b0, a} + {1'b0, b};
    else               r = {1'b0, a} - {1'b0, b};
  end
endmodule

// File: rtl/updn_counter.sv
// Loadable up/down counter with programmable step, wrap or saturate at the limits, overflow flags.
// q/ovf/ovf_sticky update one clk edge after sampling; zero/tc are combinational; no backpressure.
module updn_counter
  import updn_counter_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int SATURATE  = MODE_WRAP
) (
  input  logic          clk,
  input  logic          rst_n,
  updn_counter_if.slave bus
);
  logic [DATAWIDTH-1:0] q_r, q_nxt;
  logic                 ovf_r, ovf_nxt;
  logic                 sticky_r, sticky_nxt;
  logic [DATAWIDTH:0]   sum;
  logic                 crossed;

  step_addsub #(.DATAWIDTH(DATAWIDTH)) u_addsub (
    .a   (q_r),
    .b   (bus.step),
    .dir (bus.dir),
    .r   (sum)
  );

  // Carry-out on the way up and borrow on the way down both land in the extra bit.
  assign crossed = sum[DATAWIDTH];

  always_comb begin
    q_nxt      = q_r;
    ovf_nxt    = 1'b0;
    sticky_nxt = sticky_r;
    if (bus.load) begin
      q_nxt      = bus.ld_val;
      sticky_nxt = 1'b0;
    end else if (bus.en) begin
      q_nxt = sum[DATAWIDTH-1:0];
      if (crossed) begin
        ovf_nxt    = 1'b1;
        sticky_nxt = 1'b1;
        if (SATURATE == MODE_SAT) begin
          q_nxt = (bus.dir == DIR_UP) ? {DATAWIDTH{1'b1}} : {DATAWIDTH{1'b0}};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r      <= '0;
      ovf_r    <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      q_r      <= q_nxt;
      ovf_r    <= ovf_nxt;
      sticky_r <= sticky_nxt;
    end
  end

  assign bus.q          = q_r;
  assign bus.ovf        = ovf_r;
  assign bus.ovf_sticky = sticky_r;
  assign bus.zero       = (q_r == '0);
  assign bus.tc         = (bus.dir == DIR_DOWN) ? (q_r == '0) : (q_r == {DATAWIDTH{1'b1}});
endmodule

// File: tb/tb_updn_counter.sv
// Directed bench for updn_counter: one wrapping and one saturating instance, shared clock and reset.
module tb_updn_counter;
  import updn_counter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  updn_counter_if #(.DATAWIDTH(8)) bw ();
  updn_counter_if #(.DATAWIDTH(8)) bs ();

  updn_counter #(.DATAWIDTH(8), .SATURATE(MODE_WRAP)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bw)
  );

  updn_counter #(.DATAWIDTH(8), .SATURATE(MODE_SAT)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wset(input logic ld, input logic [7:0] lv, input logic e,
                      input logic d, input logic [7:0] st);
    bw.load = ld; bw.ld_val = lv; bw.en = e; bw.dir = d; bw.step = st;
  endtask

  task automatic sset(input logic ld, input logic [7:0] lv, input logic e,
                      input logic d, input logic [7:0] st);
    bs.load = ld; bs.ld_val = lv; bs.en = e; bs.dir = d; bs.step = st;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wset(1'b0, 8'd0, 1'b0, DIR_DOWN, 8'd0);
    sset(1'b0, 8'd0, 1'b0, DIR_DOWN, 8'd0);

    #3;
    chk("rst_q",      int'(bw.q), 0);
    chk("rst_zero",   int'(bw.zero), 1);
    chk("rst_tc",     int'(bw.tc), 1);
    chk("rst_ovf",    int'(bw.ovf), 0);
    chk("rst_sticky", int'(bw.ovf_sticky), 0);
    #9 rst_n = 1'b1;
    tick();

    // Down count from 10 to 0.
    wset(1'b1, 8'd10, 1'b0, DIR_DOWN, 8'd0);
    tick();
    chk("load10_q", int'(bw.q), 10);
    wset(1'b0, 8'd0, 1'b1, DIR_DOWN, 8'd1);
    tick();
    chk("down1_q",   int'(bw.q), 9);
    chk("down1_ovf", int'(bw.ovf), 0);
    repeat (9) tick();
    chk("down10_q",    int'(bw.q), 0);
    chk("down10_zero", int'(bw.zero), 1);
    chk("down10_tc",   int'(bw.tc), 1);
    chk("down10_ovf",  int'(bw.ovf), 0);

    // Wrap upward: 250 + 10 -> 4.
    wset(1'b1, 8'd250, 1'b0, DIR_DOWN, 8'd0);
    tick();
    wset(1'b0, 8'd0, 1'b1, DIR_UP, 8'd10);
    tick();
    chk("wrap_up_q",      int'(bw.q), 4);
    chk("wrap_up_ovf",    int'(bw.ovf), 1);
    chk("wrap_up_sticky", int'(bw.ovf_sticky), 1);
    wset(1'b0, 8'd0, 1'b0, DIR_UP, 8'd10);
    tick();
    chk("hold_q",      int'(bw.q), 4);
    chk("hold_ovf",    int'(bw.ovf), 0);
    chk("hold_sticky", int'(bw.ovf_sticky), 1);

    // Load clears sticky; wrap downward: 3 - 5 -> 254.
    wset(1'b1, 8'd3, 1'b0, DIR_DOWN, 8'd0);
    tick();
    chk("load3_sticky", int'(bw.ovf_sticky), 0);
    wset(1'b0, 8'd0, 1'b1, DIR_DOWN, 8'd5);
    tick();
    chk("wrap_dn_q",   int'(bw.q), 254);
    chk("wrap_dn_ovf", int'(bw.ovf), 1);
    chk("wrap_dn_tc",  int'(bw.tc), 0);

    // Zero step leaves q alone with no overflow.
    wset(1'b0, 8'd0, 1'b1, DIR_UP, 8'd0);
    tick();
    chk("step0_q",   int'(bw.q), 254);
    chk("step0_ovf", int'(bw.ovf), 0);

    // Terminal count while counting up at all-ones.
    wset(1'b1, 8'd255, 1'b0, DIR_UP, 8'd0);
    tick();
    chk("tc_up",   int'(bw.tc), 1);
    chk("zero_ff", int'(bw.zero), 0);
    wset(1'b0, 8'd0, 1'b1, DIR_UP, 8'd1);
    tick();
    chk("ff_inc_q",      int'(bw.q), 0);
    chk("ff_inc_sticky", int'(bw.ovf_sticky), 1);

    // Load beats enable in the same cycle.
    wset(1'b1, 8'd77, 1'b1, DIR_UP, 8'd5);
    tick();
    chk("prio_q",      int'(bw.q), 77);
    chk("prio_ovf",    int'(bw.ovf), 0);
    chk("prio_sticky", int'(bw.ovf_sticky), 0);

    // Reset pulse between edges while counting.
    wset(1'b1, 8'd0, 1'b0, DIR_UP, 8'd0);
    tick();
    wset(1'b0, 8'd0, 1'b1, DIR_UP, 8'd1);
    repeat (5) tick();
    chk("pre_rst_q", int'(bw.q), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q",    int'(bw.q), 0);
    chk("mid_rst_zero", int'(bw.zero), 1);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_q", int'(bw.q), 2);

    // Direction may flip every cycle.
    wset(1'b0, 8'd0, 1'b1, DIR_UP, 8'd3);
    tick();
    chk("dir_up_q", int'(bw.q), 5);
    wset(1'b0, 8'd0, 1'b1, DIR_DOWN, 8'd1);
    tick();
    chk("dir_dn_q", int'(bw.q), 4);
    wset(1'b0, 8'd0, 1'b0, DIR_DOWN, 8'd0);

    // Saturating instance.
    sset(1'b1, 8'd250, 1'b0, DIR_UP, 8'd0);
    tick();
    sset(1'b0, 8'd0, 1'b1, DIR_UP, 8'd10);
    tick();
    chk("sat_up_q",      int'(bs.q), 255);
    chk("sat_up_ovf",    int'(bs.ovf), 1);
    chk("sat_up_sticky", int'(bs.ovf_sticky), 1);
    tick();
    chk("sat_up2_q",   int'(bs.q), 255);
    chk("sat_up2_ovf", int'(bs.ovf), 1);
    sset(1'b1, 8'd3, 1'b0, DIR_DOWN, 8'd0);
    tick();
    chk("sat_load3_q", int'(bs.q), 3);
    sset(1'b0, 8'd0, 1'b1, DIR_DOWN, 8'd5);
    tick();
    chk("sat_dn_q",   int'(bs.q), 0);
    chk("sat_dn_ovf", int'(bs.ovf), 1);
    tick();
    chk("sat_dn2_q",   int'(bs.q), 0);
    chk("sat_dn2_ovf", int'(bs.ovf), 1);
    sset(1'b0, 8'd0, 1'b0, DIR_DOWN, 8'd5);
    tick();
    chk("sat_idle_ovf",    int'(bs.ovf), 0);
    chk("sat_idle_sticky", int'(bs.ovf_sticky), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
